// File: rtl/switch_pkg.sv
// Shared switch-port constants and sizing helpers.
// Latency: n/a (package).
// Backpressure: n/a (package).
package switch_pkg;

    // Default buffer geometry used by every switch port instance.
    localparam int SW_FIFO_DEPTH = 64;
    localparam int SW_FIFO_W     = 8;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port memory, W_WIDTH x DEPTH, one write and one read port.
// Latency: 1 cycle, registered read data (rd_dat updates on the edge after rd_en).
// Backpressure: none; rd_dat holds its value when rd_en is low. No reset.
//
// Ports: clk; wr_en/wr_addr/wr_dat write port; rd_en/rd_addr read request;
//        rd_dat registered read data.
module fifo_ram #(
    parameter int DEPTH   = 64,
    parameter int W_WIDTH = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [W_WIDTH-1:0] wr_dat,
    input  logic               rd_en,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [W_WIDTH-1:0] rd_dat
);

    logic [W_WIDTH-1:0] mem [DEPTH];

    // Same-address write and read in one cycle returns the old word, which
    // is what a full FIFO doing a simultaneous push/pop needs.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_sync_flags.sv
// Synchronous FIFO with level flags, occupancy count and sticky error flags.
// Latency: 1 cycle from accepted rd_en to rd_valid/data_out; flags follow the registered count.
// Backpressure: push rejected when full (unless popping), pop rejected when empty; rejects set overflow/underflow.
//
// Ports: clk, rst_n (sync, active-low); wr_en/data_in push; rd_en pop;
//        data_out/rd_valid read result; full/empty/almost_full/almost_empty/count
//        status; err_clr clears overflow/underflow sticky errors.
module fifo_sync_flags
    import switch_pkg::*;
#(
    parameter int DEPTH    = SW_FIFO_DEPTH,
    parameter int W_WIDTH  = SW_FIFO_W,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4,
    localparam int ADDR_W  = $clog2(DEPTH),
    localparam int CNT_W   = cnt_w(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [W_WIDTH-1:0] data_in,
    input  logic               rd_en,
    output logic [W_WIDTH-1:0] data_out,
    output logic               rd_valid,
    output logic               full,
    output logic               empty,
    output logic               almost_full,
    output logic               almost_empty,
    output logic [CNT_W-1:0]   count,
    input  logic               err_clr,
    output logic               overflow,
    output logic               underflow
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic               wr_acc;
    logic               rd_acc;
    logic               rd_seen;
    logic [W_WIDTH-1:0] ram_rd_dat;

    // Flags are pure compares of the registered count.
    assign full         = (count == FULL_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    // A pop on a full FIFO frees the slot the push needs. An empty FIFO
    // never pops, even with a concurrent push (no bypass).
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_en);

    fifo_ram #(
        .DEPTH   (DEPTH),
        .W_WIDTH (W_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_dat  (data_in),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_dat  (ram_rd_dat)
    );

    // The RAM read register has no reset, so data_out reads as zero until
    // the first pop after reset. After that the RAM register holds the last
    // popped word because its read enable is the accepted pop.
    assign data_out = rd_seen ? ram_rd_dat : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_valid  <= 1'b0;
            rd_seen   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rd_valid <= rd_acc;

            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr  <= rd_ptr + ADDR_W'(1);
                rd_seen <= 1'b1;
            end

            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            // A new error event in the same cycle as err_clr keeps the flag set.
            if (wr_en && !wr_acc) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end

            if (rd_en && !rd_acc) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Self-checking bench for fifo_sync_flags against a queue-based reference model.
// Latency: model expects read data one cycle after an accepted pop.
// Backpressure: model applies the accept/reject rules and sticky errors.
module tb_fifo_sync_flags;

    localparam int DEPTH = 64;
    localparam int W     = 8;
    localparam int AF    = 60;
    localparam int AE    = 4;

    logic         clk;
    logic         rst_n;
    logic         wr_en;
    logic [W-1:0] data_in;
    logic         rd_en;
    logic [W-1:0] data_out;
    logic         rd_valid;
    logic         full;
    logic         empty;
    logic         almost_full;
    logic         almost_empty;
    logic [6:0]   count;
    logic         err_clr;
    logic         overflow;
    logic         underflow;

    fifo_sync_flags #(
        .DEPTH    (DEPTH),
        .W_WIDTH  (W),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .data_out     (data_out),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .err_clr      (err_clr),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    logic [W-1:0] q[$];
    logic [W-1:0] m_dout;
    bit           m_rv;
    bit           m_ov;
    bit           m_uf;

    int total  = 0;
    int passed = 0;
    int fails  = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("count",        32'(count),        32'(n));
        chk("empty",        32'(empty),        32'(n == 0));
        chk("full",         32'(full),         32'(n == DEPTH));
        chk("almost_full",  32'(almost_full),  32'(n >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
        chk("rd_valid",     32'(rd_valid),     32'(m_rv));
        chk("data_out",     32'(data_out),     32'(m_dout));
        chk("overflow",     32'(overflow),     32'(m_ov));
        chk("underflow",    32'(underflow),    32'(m_uf));
    endtask

    // One clock: drive inputs, apply the rules to the model, check after the edge.
    task automatic step(input bit w, input logic [W-1:0] d, input bit r, input bit c, input bit rs);
        bit was_empty, was_full, ra, wa;
        rst_n   = rs;
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        err_clr = c;
        @(posedge clk);
        cyc++;
        if (!rs) begin
            q.delete();
            m_dout = '0;
            m_rv   = 0;
            m_ov   = 0;
            m_uf   = 0;
        end else begin
            was_empty = (q.size() == 0);
            was_full  = (q.size() == DEPTH);
            ra = r && !was_empty;
            wa = w && (!was_full || r);
            m_rv = ra;
            if (ra) m_dout = q.pop_front();
            if (wa) q.push_back(d);
            if (w && !wa) m_ov = 1;
            else if (c)   m_ov = 0;
            if (r && !ra) m_uf = 1;
            else if (c)   m_uf = 0;
        end
        #1;
        check_all();
    endtask

    task automatic push(input logic [W-1:0] d);
        step(1, d, 0, 0, 1);
    endtask

    task automatic pop();
        step(0, '0, 1, 0, 1);
    endtask

    task automatic idle();
        step(0, '0, 0, 0, 1);
    endtask

    initial begin
        rst_n = 0; wr_en = 0; data_in = '0; rd_en = 0; err_clr = 0;
        m_dout = '0; m_rv = 0; m_ov = 0; m_uf = 0;

        // Reset state.
        step(0, '0, 0, 0, 0);
        step(0, '0, 0, 0, 0);

        // Three words through, in order, one-cycle read latency.
        push(8'h11); push(8'h22); push(8'h33);
        pop(); pop(); pop();
        idle();

        // Fill to full, overflow, then drain across the pointer wrap.
        for (int i = 0; i < DEPTH; i++) push(8'(i));
        push(8'hEE);
        for (int i = 0; i < DEPTH; i++) pop();
        idle();
        step(0, '0, 0, 1, 1);

        // Underflow, clear, and set-wins-over-clear.
        pop();
        step(0, '0, 0, 1, 1);
        step(0, '0, 1, 1, 1);
        step(0, '0, 0, 1, 1);

        // Full with simultaneous push/pop, then empty with push/pop.
        for (int i = 0; i < DEPTH; i++) push(8'(8'h80 + i));
        for (int i = 0; i < 10; i++) step(1, 8'(8'hC0 + i), 1, 0, 1);
        for (int i = 0; i < DEPTH; i++) pop();
        step(1, 8'h5A, 1, 0, 1);
        pop();
        idle();

        // Mid-stream reset discards contents; new data round-trips.
        step(0, '0, 0, 1, 1);
        for (int i = 0; i < 20; i++) push(8'(8'h40 + i));
        pop();
        step(0, '0, 0, 0, 0);
        push(8'hA5); push(8'h5A);
        pop(); pop();
        idle();

        // Randomized traffic, with bias phases to reach both full and empty.
        for (int i = 0; i < 3000; i++) begin
            int ph;
            bit w, r, c, rs;
            ph = (i / 300) % 3;
            w  = (ph == 0) ? ($urandom_range(0, 9) < 8) :
                 (ph == 1) ? ($urandom_range(0, 9) < 2) : $urandom_range(0, 1);
            r  = (ph == 0) ? ($urandom_range(0, 9) < 2) :
                 (ph == 1) ? ($urandom_range(0, 9) < 8) : $urandom_range(0, 1);
            c  = ($urandom_range(0, 15) == 0);
            rs = ($urandom_range(0, 999) != 0);
            step(w, 8'($urandom), r, c, rs);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fifo_sync_flags.md
Name: fifo_sync_flags

Overview:
- Parametrised synchronous FIFO for switch ingress/egress buffering.
- Generalises the single-depth/width buffer with:
  - full/empty and programmable almost-full/almost-empty flags
  - occupancy count
  - read-valid strobe
  - protected push/pop on full/empty
  - sticky overflow/underflow error flags
- Sits between the port receive logic and the arbiter; one instance per switch port.

Parameters:
- DEPTH, 64, number of entries; power of two, >= 4.
- W_WIDTH, 8, data word width in bits.
- AF_LEVEL, DEPTH-4, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- wr_en  in  1  push request.
- data_in  in  W_WIDTH  push data.
- rd_en  in  1  pop request.
- data_out  out  W_WIDTH  popped word; valid when rd_valid=1.
- rd_valid  out  1  data_out carries the word popped in the previous cycle.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- err_clr  in  1  clears sticky error flags.
- overflow  out  1  sticky: a push was rejected.
- underflow  out  1  sticky: a pop was rejected.

Behaviour:
- Reset:
  - Sampled on the clk rising edge when rst_n=0, so it is synchronous.
  - Clears wr_ptr, rd_ptr, count, data_out, rd_valid, overflow and underflow to 0.
  - Flags after reset: empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0, never legal)=0.
  - RAM contents are not reset.
  - A reset applied mid-operation discards all stored data; the first push after reset lands in entry 0.
- Pointers:
  - Width ADDR_W=$clog2(DEPTH).
  - Wrap from DEPTH-1 to 0 by natural overflow.
- Accept rules, all evaluated on pre-edge state:
  - rd_acc = rd_en && !empty.
  - wr_acc = wr_en && (!full || rd_en). When full, a simultaneous pop frees the slot and both are accepted.
  - When empty, wr_en and rd_en together: the write is accepted and the read is rejected. There is no bypass path.
- On a rising edge with wr_acc:
  - ram[wr_ptr] <= data_in.
  - wr_ptr increments.
- On a rising edge with rd_acc:
  - data_out <= ram[rd_ptr].
  - rd_ptr increments.
  - rd_valid <= 1.
- Without rd_acc: rd_valid <= 0 and data_out holds its last value. It is not zeroed.
- Read latency: 1 cycle from the rd_en sample to rd_valid/data_out.
- count update:
  - +1 if wr_acc only; -1 if rd_acc only; unchanged if both or neither.
  - count is a registered value; all four level flags are combinational compares of the registered count.
  - Flags therefore change in the cycle after the accepted operation.
- Error flags:
  - overflow <= 1 on wr_en && !wr_acc.
  - underflow <= 1 on rd_en && !rd_acc.
  - err_clr=1 clears both on the next edge.
  - If a set event and err_clr occur in the same cycle, the set wins.
  - Rejected operations never move pointers or change count.
- Full-to-empty and empty-to-full transitions must be exact at DEPTH; no entry may be lost at pointer wrap.

Decomposition:
- Shared package switch_pkg holds:
  - the default DEPTH/W_WIDTH constants used across switch ports
  - a localparam function for the count width ($clog2(DEPTH)+1)
- One sub-module, fifo_ram: simple dual-port memory, W_WIDTH x DEPTH.
  - Synchronous write port.
  - Registered synchronous read port, which supplies the 1-cycle read latency.
  - No reset.
- Pointer, count, flag and error logic stays in fifo_sync_flags.

Test Plan:
- Reset then push 0x11, 0x22, 0x33 on consecutive cycles, then pop 3 → rd_valid high for 3 cycles, starting 1 cycle after the first rd_en; data_out = 0x11, 0x22, 0x33; count returns to 0 and empty=1.
- Push DEPTH=64 words 0..63 → full=1 and count=64 the cycle after the 64th push; a 65th push sets overflow=1 with count still 64; pop all 64 → values 0..63 in order, with no corruption at the wrap.
- Pop while empty → underflow=1, rd_valid=0, data_out unchanged; err_clr pulse → underflow=0 the next cycle; err_clr together with a new empty pop → underflow stays 1.
- Full FIFO with wr_en=rd_en=1 for 10 cycles → no overflow, count stays 64, read data continues in order; empty FIFO with wr_en=rd_en=1 → count becomes 1, underflow=1.
- Threshold check with AF_LEVEL=60, AE_LEVEL=4 → almost_empty=1 at count 4 and 0 at count 5; almost_full=0 at count 59 and 1 at count 60.
- Fill to 20 entries, then hold rst_n=0 for 1 cycle mid-stream → count=0, empty=1, rd_valid=0, data_out=0, errors cleared; the next push/pop round-trips the new data correctly.
